// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
//   Round-robin arbiter and sequencer that lets NUM_REQ requesters share one
//   booth_radix8_multiplier. A single multiply is in flight at any time. Its
//   result is returned only to the requester that was granted it.
//
// Ports
//   clk, rst_n          : clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready : per-requester request handshake (at most one ready)
//   req_a, req_b        : packed operands, slice i belongs to requester i
//   req_mode            : packed 2-bit sign modes {a_signed, b_signed}
//   rsp_valid/rsp_ready : per-requester response handshake (one-hot valid)
//   rsp_product         : shared product register, valid where rsp_valid is set
//   grant_id            : index of the current owner
//   arb_busy            : high whenever the sequencer is not idle
//   mult_*              : start pulse, operands and sign mode to the multiplier,
//                         plus its product, done and busy flags coming back
module booth_mult_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]     req_mode,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic [IDW-1:0]           grant_id,
  output logic                     arb_busy,
  output logic                     mult_start,
  output logic [WIDTH-1:0]         mult_multiplicand,
  output logic [WIDTH-1:0]         mult_multiplier,
  output logic [1:0]               mult_sign_mode,
  input  logic [2*WIDTH-1:0]       mult_product,
  input  logic                     mult_done,
  input  logic                     mult_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   winner;
  logic             win_found;
  logic             req_fire;
  logic             own_rsp_ready;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [1:0]       sel_mode;

  // Round-robin scan: start one past the last owner and take the first
  // valid requester, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    winner    = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        winner    = IDW'(idx);
      end
    end
  end

  // A request is only accepted while idle and the multiplier is free.
  assign req_fire = (state == IDLE) && !mult_busy && win_found;
  assign arb_busy = (state != IDLE);

  // Decode the winner and the owner into one-hot handshakes and mux the
  // winning operand slices with constant indices.
  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    own_rsp_ready = 1'b0;
    sel_a         = '0;
    sel_b         = '0;
    sel_mode      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        req_ready[i] = req_fire;
        sel_a        = req_a[i*WIDTH +: WIDTH];
        sel_b        = req_b[i*WIDTH +: WIDTH];
        sel_mode     = req_mode[i*2 +: 2];
      end
      if (grant_id == IDW'(i)) begin
        rsp_valid[i]  = (state == RESP);
        own_rsp_ready = rsp_ready[i];
      end
    end
  end

  // Sequencer. mult_done is only looked at in WAIT, so a done flag left over
  // from the previous operation during ISSUE cannot be mistaken for a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      last_grant        <= IDW'(NUM_REQ - 1);
      grant_id          <= '0;
      rsp_product       <= '0;
      mult_start        <= 1'b0;
      mult_multiplicand <= '0;
      mult_multiplier   <= '0;
      mult_sign_mode    <= '0;
    end else begin
      mult_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            grant_id          <= winner;
            mult_multiplicand <= sel_a;
            mult_multiplier   <= sel_b;
            mult_sign_mode    <= sel_mode;
            mult_start        <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mult_done) begin
            rsp_product <= mult_product;
            state       <= RESP;
          end
        end
        RESP: begin
          if (own_rsp_ready) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter
//   Self-checking bench for booth_mult_arbiter. A behavioural multiplier model
//   answers mult_start after a programmable latency. Per-requester operand
//   queues feed the request ports. A scoreboard records the expected product
//   and owner at each request handshake and compares them at the response
//   handshake. Directed sequences cover timing, backpressure, busy, stale done,
//   withdrawal, reset and fairness, followed by a random soak.
module tb_booth_mult_arbiter;

  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 4;
  localparam int IDW     = $clog2(NUM_REQ);
  localparam int QD      = 1024;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*2-1:0]     req_mode;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [2*WIDTH-1:0]       rsp_product;
  logic [IDW-1:0]           grant_id;
  logic                     arb_busy;
  logic                     mult_start;
  logic [WIDTH-1:0]         mult_multiplicand;
  logic [WIDTH-1:0]         mult_multiplier;
  logic [1:0]               mult_sign_mode;
  logic [2*WIDTH-1:0]       mult_product;
  logic                     mult_done;
  logic                     mult_busy;

  booth_mult_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_a             (req_a),
    .req_b             (req_b),
    .req_mode          (req_mode),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_product       (rsp_product),
    .grant_id          (grant_id),
    .arb_busy          (arb_busy),
    .mult_start        (mult_start),
    .mult_multiplicand (mult_multiplicand),
    .mult_multiplier   (mult_multiplier),
    .mult_sign_mode    (mult_sign_mode),
    .mult_product      (mult_product),
    .mult_done         (mult_done),
    .mult_busy         (mult_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Sign-extend each operand as its mode bit says, multiply, keep 2*WIDTH bits.
  function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] mode);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    logic signed [63:0] p;
    ea = mode[1] ? {{48{a[15]}}, a} : {48'd0, a};
    eb = mode[0] ? {{48{b[15]}}, b} : {48'd0, b};
    p  = ea * eb;
    return p[31:0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_check(input string name);
    n_checks++;
    n_err++;
    $display("[TB] FAIL %s: got no completion, expected completion", name);
  endtask

  // ---------------- behavioural multiplier ----------------
  int          mlat       = 3;
  logic        force_busy = 1'b0;
  logic        force_done = 1'b0;
  logic        m_busy;
  logic        m_done;
  logic [31:0] m_prod;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (mult_start) begin
        m_busy <= 1'b1;
        m_cnt  <= (mlat == 0) ? int'($urandom_range(1, 6)) : mlat;
        m_prod <= golden(mult_multiplicand, mult_multiplier, mult_sign_mode);
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  assign mult_busy    = m_busy | force_busy;
  assign mult_done    = m_done | force_done;
  assign mult_product = force_done ? 32'hDEADBEEF : m_prod;

  // ---------------- stimulus queues and driver ----------------
  logic [15:0] q_a   [NUM_REQ][QD];
  logic [15:0] q_b   [NUM_REQ][QD];
  logic [1:0]  q_m   [NUM_REQ][QD];
  logic [31:0] q_exp [NUM_REQ][QD];
  int          q_head [NUM_REQ];
  int          q_tail [NUM_REQ];

  logic               drive_en   = 1'b1;
  logic               rsp_rand   = 1'b0;
  logic [NUM_REQ-1:0] rsp_manual = '1;
  logic [NUM_REQ-1:0] acc_mask   = '0;

  task automatic apply_stimulus(input int id, input logic [15:0] a, input logic [15:0] b,
                                input logic [1:0] mode, input logic [31:0] exp);
    if (q_head[id] == q_tail[id]) begin
      q_head[id] = 0;
      q_tail[id] = 0;
    end
    q_a[id][q_tail[id]]   = a;
    q_b[id][q_tail[id]]   = b;
    q_m[id][q_tail[id]]   = mode;
    q_exp[id][q_tail[id]] = exp;
    q_tail[id]++;
  endtask

  // Advance one clock and re-drive inputs just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc_mask[i] && q_head[i] < q_tail[i]) q_head[i]++;
    if (drive_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (q_head[i] < q_tail[i]) begin
          req_valid[i]              = 1'b1;
          req_a[i*WIDTH +: WIDTH]   = q_a[i][q_head[i]];
          req_b[i*WIDTH +: WIDTH]   = q_b[i][q_head[i]];
          req_mode[i*2 +: 2]        = q_m[i][q_head[i]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      rsp_ready[i] = rsp_rand ? ($urandom_range(0, 99) < 70) : rsp_manual[i];
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          sb_id   [$];
  logic [31:0] sb_prod [$];
  int          grant_log [$];
  int          grant_total = 0;
  int          rsp_count   = 0;
  logic [NUM_REQ-1:0] waiting = '0;
  int          wait_start [NUM_REQ];

  always @(negedge clk) begin
    acc_mask = '0;
    if (!rst_n) begin
      waiting = '0;
    end else begin
      check_output("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      check_output("rsp_valid_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
      if (|(rsp_valid & rsp_ready)) begin
        if (sb_id.size() == 0) begin
          fail_check("rsp_without_request");
        end else begin
          int          id;
          logic [31:0] p;
          id = sb_id.pop_front();
          p  = sb_prod.pop_front();
          check_output("rsp_valid_owner", 32'(rsp_valid), 32'(1 << id));
          check_output("rsp_product", rsp_product, p);
          rsp_count++;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i]) begin
          waiting[i] = 1'b0;
        end else if (!waiting[i]) begin
          waiting[i]    = 1'b1;
          wait_start[i] = grant_total;
        end
        if (req_valid[i] && req_ready[i]) begin
          acc_mask[i] = 1'b1;
          check_output("fairness", 32'((grant_total - wait_start[i]) <= NUM_REQ - 1), 32'd1);
          grant_total++;
          waiting[i] = 1'b0;
          grant_log.push_back(i);
          sb_id.push_back(i);
          sb_prod.push_back(q_exp[i][q_head[i]]);
        end
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      @(negedge clk);
      done = 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        if (q_head[i] != q_tail[i]) done = 1'b0;
      if (sb_id.size() != 0 || arb_busy || acc_mask != '0) done = 1'b0;
    end
    if (!done) fail_check({"timeout_", name});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      q_head[i] = 0;
      q_tail[i] = 0;
    end
    sb_id.delete();
    sb_prod.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  mode;
    logic [31:0] prod;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen_done;
    bit got;
    int base;

    vecs[0] = '{0, 16'h000A, 16'h0005, 2'b00, 32'h00000032};
    vecs[1] = '{0, 16'hFFF6, 16'h000A, 2'b10, 32'hFFFFFF9C};
    vecs[2] = '{1, 16'hFFFF, 16'hFFFF, 2'b00, 32'hFFFE0001};
    vecs[3] = '{1, 16'hFFFF, 16'hFFFF, 2'b11, 32'h00000001};
    vecs[4] = '{2, 16'h8000, 16'h8000, 2'b11, 32'h40000000};
    vecs[5] = '{3, 16'h0003, 16'hFFFF, 2'b01, 32'hFFFFFFFD};
    vecs[6] = '{3, 16'hFFFF, 16'h0002, 2'b01, 32'h0001FFFE};
    vecs[7] = '{2, 16'h8000, 16'h7FFF, 2'b11, 32'hC0008000};
    vecs[8] = '{0, 16'h1234, 16'h0000, 2'b11, 32'h00000000};
    vecs[9] = '{1, 16'h8000, 16'hFFFF, 2'b10, 32'h80008000};

    for (int i = 0; i < NUM_REQ; i++) begin
      q_head[i] = 0;
      q_tail[i] = 0;
    end
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_mode  = '0;
    rsp_ready = '1;

    // Reset values
    @(negedge clk);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rsp_product", rsp_product, 32'd0);
    check_output("rst_grant_id", 32'(grant_id), 32'd0);
    check_output("rst_arb_busy", 32'(arb_busy), 32'd0);
    check_output("rst_mult_start", 32'(mult_start), 32'd0);
    check_output("rst_mult_a", 32'(mult_multiplicand), 32'd0);
    check_output("rst_mult_b", 32'(mult_multiplier), 32'd0);
    check_output("rst_mult_mode", 32'(mult_sign_mode), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Handshake-to-start timing and done-to-response latency
    $display("[TB] basic timing");
    mlat = 3;
    apply_stimulus(0, 16'h000A, 16'h0005, 2'b00, 32'h00000032);
    tick();
    @(negedge clk);
    check_output("first_req_ready", 32'(req_ready), 32'b0001);
    tick();
    @(negedge clk);
    check_output("issue_mult_start", 32'(mult_start), 32'd1);
    check_output("issue_mult_a", 32'(mult_multiplicand), 32'h000A);
    check_output("issue_mult_b", 32'(mult_multiplier), 32'h0005);
    check_output("issue_mult_mode", 32'(mult_sign_mode), 32'd0);
    check_output("issue_grant_id", 32'(grant_id), 32'd0);
    check_output("issue_arb_busy", 32'(arb_busy), 32'd1);
    tick();
    @(negedge clk);
    check_output("wait_mult_start", 32'(mult_start), 32'd0);
    seen_done = 1'b0;
    got       = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      @(negedge clk);
      if (seen_done) begin
        check_output("done_to_rsp_valid", 32'(rsp_valid), 32'b0001);
        got = 1'b1;
      end
      if (mult_done) seen_done = 1'b1;
    end
    if (!got) fail_check("basic_done");
    wait_idle(50, "basic");

    // Table-driven vectors, one transaction at a time
    $display("[TB] vector table");
    for (int v = 0; v < 10; v++) begin
      apply_stimulus(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].mode, vecs[v].prod);
      wait_idle(200, "vector");
    end

    // All requesters at once right after reset: order must be 0,1,2,3,0,...
    $display("[TB] simultaneous requests");
    do_reset();
    grant_log.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NUM_REQ; i++)
        apply_stimulus(i, 16'(100 * i + k + 1), 16'(7 * i + 3 + k), 2'(i),
                       golden(16'(100 * i + k + 1), 16'(7 * i + 3 + k), 2'(i)));
    wait_idle(500, "simultaneous");
    check_output("grant_count", 32'(grant_log.size()), 32'd8);
    if (grant_log.size() >= 8)
      for (int k = 0; k < 8; k++)
        check_output("grant_order", 32'(grant_log[k]), 32'(k % NUM_REQ));

    // Response backpressure on requester 2, non-owner ready bits high
    $display("[TB] response backpressure");
    rsp_manual = 4'b1011;
    apply_stimulus(2, 16'h8000, 16'h8000, 2'b11, 32'h40000000);
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      tick();
      @(negedge clk);
      if (rsp_valid[2]) got = 1'b1;
    end
    if (!got) fail_check("backpressure_rsp");
    apply_stimulus(0, 16'h0007, 16'h0009, 2'b00, 32'h0000003F);
    for (int n = 0; n < 10; n++) begin
      tick();
      @(negedge clk);
      check_output("bp_rsp_valid", 32'(rsp_valid), 32'b0100);
      check_output("bp_rsp_product", rsp_product, 32'h40000000);
      check_output("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_manual = '1;
    wait_idle(100, "backpressure");

    // Multiplier busy blocks arbitration
    $display("[TB] busy multiplier");
    force_busy = 1'b1;
    apply_stimulus(3, 16'h0012, 16'h0034, 2'b00, 32'h000003A8);
    for (int n = 0; n < 5; n++) begin
      tick();
      @(negedge clk);
      check_output("busy_req_ready", 32'(req_ready), 32'd0);
      check_output("busy_arb_busy", 32'(arb_busy), 32'd0);
    end
    force_busy = 1'b0;
    wait_idle(100, "busy");

    // Stale done during ISSUE must not be captured
    $display("[TB] stale done");
    mlat = 5;
    apply_stimulus(1, 16'h0100, 16'h0100, 2'b00, 32'h00010000);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      @(negedge clk);
      if (req_ready[1]) got = 1'b1;
    end
    if (!got) fail_check("stale_grant");
    tick();
    force_done = 1'b1;
    @(negedge clk);
    check_output("stale_in_issue", 32'(mult_start), 32'd1);
    tick();
    force_done = 1'b0;
    @(negedge clk);
    check_output("stale_done_ignored", 32'(rsp_valid), 32'd0);
    wait_idle(100, "stale");

    // Withdrawn request while the multiplier is busy has no effect
    $display("[TB] withdrawn request");
    drive_en   = 1'b0;
    force_busy = 1'b1;
    tick();
    req_valid = 4'b0010;
    req_a[WIDTH +: WIDTH] = 16'h0BAD;
    @(negedge clk);
    check_output("withdraw_req_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid  = '0;
    force_busy = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      @(negedge clk);
      check_output("withdraw_arb_busy", 32'(arb_busy), 32'd0);
      check_output("withdraw_mult_start", 32'(mult_start), 32'd0);
    end
    drive_en = 1'b1;

    // Reset during WAIT, then a clean transaction from requester 0
    $display("[TB] reset mid-wait");
    mlat = 8;
    apply_stimulus(1, 16'h00AB, 16'h00CD, 2'b00, 32'h000088EF);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      @(negedge clk);
      if (mult_start) got = 1'b1;
    end
    if (!got) fail_check("reset_issue");
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("arst_rsp_product", rsp_product, 32'd0);
    check_output("arst_grant_id", 32'(grant_id), 32'd0);
    check_output("arst_arb_busy", 32'(arb_busy), 32'd0);
    check_output("arst_mult_start", 32'(mult_start), 32'd0);
    check_output("arst_mult_a", 32'(mult_multiplicand), 32'd0);
    check_output("arst_mult_b", 32'(mult_multiplier), 32'd0);
    check_output("arst_mult_mode", 32'(mult_sign_mode), 32'd0);
    check_output("arst_req_ready", 32'(req_ready), 32'd0);
    sb_id.delete();
    sb_prod.delete();
    tick();
    tick();
    rst_n = 1'b1;
    mlat  = 3;
    apply_stimulus(0, 16'h0FFF, 16'h0011, 2'b11, 32'h00010FEF);
    wait_idle(100, "after_reset");

    // Random soak with response stalls and random latency
    $display("[TB] random soak");
    mlat     = 0;
    rsp_rand = 1'b1;
    base     = rsp_count;
    for (int t = 0; t < 400; t++) begin
      int          id;
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  m;
      id = int'($urandom_range(0, NUM_REQ - 1));
      a  = 16'($urandom);
      b  = 16'($urandom);
      m  = 2'($urandom);
      apply_stimulus(id, a, b, m, golden(a, b, m));
    end
    wait_idle(30000, "soak");
    rsp_rand = 1'b0;
    check_output("soak_rsp_count", 32'(rsp_count - base), 32'd400);
    check_output("scoreboard_empty", 32'(sb_id.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
